// File: rtl/ws2812b_frame_sequencer.sv
// ws2812b_frame_sequencer
// Streams a small GRB pixel buffer into the ws2812b core, one pixel per
// valid/ready handshake. A global brightness scale is applied, and latch is
// raised on the last pixel. The CPU register decode writes the buffer and
// issues a start; the sequencer then owns the handshake until the frame ends.

module ws2812b_frame_sequencer #(
    parameter int NUM_PIXELS = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [23:0]       rd_data,
    input  logic [7:0]        brightness,
    input  logic [ADDR_W:0]   count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [23:0]       px_data,
    output logic              px_valid,
    output logic              px_latch,
    input  logic              px_ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PUSH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   NUM_PX_C = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(NUM_PIXELS - 1);

    // Scale one 8-bit channel by (bri + 1) / 256, so 255 is identity and 0 blanks.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

    // Scale all three channels of a GRB pixel.
    function automatic logic [23:0] scale_px(input logic [23:0] p, input logic [7:0] b);
        return {scale_ch(p[23:16], b), scale_ch(p[15:8], b), scale_ch(p[7:0], b)};
    endfunction

    logic [23:0]       buf_r [NUM_PIXELS];
    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] eff_last_s;
    logic [7:0]        bri_r;
    logic [23:0]       px_data_r;
    logic              px_latch_r;
    logic              px_valid_r;
    logic              busy_r;
    logic              done_r;

    assign rd_data  = buf_r[rd_addr];
    assign px_data  = px_data_r;
    assign px_latch = px_latch_r;
    assign px_valid = px_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Pixel buffer: written from the register side in any state, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_r[wr_addr] <= wr_data;
        end
    end

    // Index of the last pixel to send, clamping oversize counts to the buffer depth.
    always_comb begin
        eff_last_s = LAST_C;
        if (count >= NUM_PX_C) begin
            eff_last_s = LAST_C;
        end else begin
            eff_last_s = count[ADDR_W-1:0] - ADDR_W'(1);
        end
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (count != {(ADDR_W+1){1'b0}})) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                next_state_s = ST_PUSH;
            end
            ST_PUSH: begin
                if (px_ready) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_PUSH;
                end
            end
            ST_DRAIN: begin
                // Wait for ready to fall so a lingering ready cannot re-accept.
                if (px_ready) begin
                    next_state_s = ST_DRAIN;
                end else if (idx_r == last_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, frame context, pixel output and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= {ADDR_W{1'b0}};
            last_r     <= {ADDR_W{1'b0}};
            bri_r      <= 8'd0;
            px_data_r  <= 24'd0;
            px_latch_r <= 1'b0;
            px_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            px_valid_r <= (next_state_s == ST_PUSH);
            done_r     <= (next_state_s == ST_DONE);
            busy_r     <= (next_state_s == ST_FETCH) || (next_state_s == ST_PUSH) ||
                          (next_state_s == ST_DRAIN);
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_FETCH) begin
                        idx_r  <= {ADDR_W{1'b0}};
                        last_r <= eff_last_s;
                        bri_r  <= brightness;
                    end
                end
                ST_FETCH: begin
                    // Reads the pre-write value if the same index is written now.
                    px_data_r  <= scale_px(buf_r[idx_r], bri_r);
                    px_latch_r <= (idx_r == last_r);
                end
                ST_DRAIN: begin
                    if (next_state_s == ST_FETCH) begin
                        idx_r <= idx_r + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench for ws2812b_frame_sequencer: a software core model serves
// each pixel and compares it against a scoreboard of expected pixels filled
// at frame start from a local copy of the buffer.

module tb_ws2812b_frame_sequencer;

    localparam int NP = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = 24'd0;
    logic [AW-1:0] rd_addr = '0;
    logic [23:0]   rd_data;
    logic [7:0]    brightness = 8'd255;
    logic [AW:0]   count = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [23:0]   px_data;
    logic          px_valid;
    logic          px_latch;
    logic          px_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    logic [23:0] model [NP];
    logic [24:0] exp_q [$];

    ws2812b_frame_sequencer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .brightness(brightness), .count(count),
        .start(start), .busy(busy), .done(done), .px_data(px_data), .px_valid(px_valid),
        .px_latch(px_latch), .px_ready(px_ready)
    );

    always #5 clk = ~clk;

    // Count accepted transfers and done pulses seen at the active edge.
    always @(posedge clk) begin
        if (px_valid && px_ready) xfer_cnt <= xfer_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [7:0] ref_scale(input logic [7:0] c, input logic [7:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) / 256;
        return v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input int cnt, input logic [7:0] bri);
        int n;
        logic [23:0] p;
        n = (cnt > NP) ? NP : cnt;
        for (int i = 0; i < n; i++) begin
            p = {ref_scale(model[i][23:16], bri), ref_scale(model[i][15:8], bri),
                 ref_scale(model[i][7:0], bri)};
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, p});
        end
        @(negedge clk);
        count = (AW+1)'(cnt); brightness = bri; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, (n > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!px_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("valid_timeout", {31'd0, px_valid}, 32'd1);
    endtask

    // Serve one pixel: optional stall with stability checks, then accept.
    task automatic serve(input int delay, input bit hold2);
        logic [24:0] e;
        wait_valid();
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, px_valid}, 32'd1);
            chk("stall_data", {8'd0, px_data}, {8'd0, exp_q[0][23:0]});
        end
        e = exp_q.pop_front();
        chk("px_data", {8'd0, px_data}, {8'd0, e[23:0]});
        chk("px_latch", {31'd0, px_latch}, {31'd0, e[24]});
        px_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", {31'd0, px_valid}, 32'd0);
        if (hold2) begin
            @(negedge clk);
            chk("no_dup_valid", {31'd0, px_valid}, 32'd0);
        end
        px_ready = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int x0;
        int d0;
        logic [24:0] e;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, px_valid}, 32'd0);
        chk("rst_latch", {31'd0, px_latch}, 32'd0);
        chk("rst_data", {8'd0, px_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame
        wr(0, 24'h110000); wr(1, 24'h002200); wr(2, 24'h000033);
        rd_addr = 3'd1;
        #1 chk("readback", {8'd0, rd_data}, 32'h00002200);
        x0 = xfer_cnt; d0 = done_cnt;
        start_frame(3, 8'd255);
        for (int i = 0; i < 3; i++) serve(5, 1'b0);
        wait_done();
        chk("basic_xfers", xfer_cnt - x0, 32'd3);
        chk("basic_dones", done_cnt - d0, 32'd1);

        // Scaling
        wr(0, 24'hFF8001);
        start_frame(1, 8'd127);
        chk("scale_const", {8'd0, exp_q[0][23:0]}, 32'h007F4000);
        serve(0, 1'b0);
        wait_done();
        start_frame(1, 8'd0);
        serve(0, 1'b0);
        wait_done();

        // Count zero is ignored
        d0 = done_cnt;
        start_frame(0, 8'd255);
        repeat (5) @(negedge clk);
        chk("cnt0_busy", {31'd0, busy}, 32'd0);
        chk("cnt0_done", done_cnt - d0, 32'd0);

        // Oversize count with stall and lingering ready
        for (int i = 0; i < NP; i++) wr(i, 24'h010203 * (i + 1));
        x0 = xfer_cnt;
        start_frame(15, 8'd200);
        for (int i = 0; i < NP; i++) serve((i == 1) ? 50 : 0, (i == 3) ? 1'b1 : 1'b0);
        wait_done();
        chk("clamp_xfers", xfer_cnt - x0, 32'd8);

        // Concurrency: mid-frame write, start, brightness change
        x0 = xfer_cnt; d0 = done_cnt;
        start_frame(4, 8'd255);
        wait_valid();
        wr(2, 24'hABCDEF);
        exp_q[2] = {1'b0, 24'hABCDEF};
        @(negedge clk);
        start = 1'b1; brightness = 8'd0; count = 4'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) serve(0, 1'b0);
        wait_done();
        chk("conc_xfers", xfer_cnt - x0, 32'd4);
        chk("conc_dones", done_cnt - d0, 32'd1);

        // Reset during DRAIN of pixel 1 of 4
        for (int i = 0; i < 4; i++) wr(i, 24'h100000 + 24'(i));
        d0 = done_cnt;
        start_frame(4, 8'd255);
        serve(0, 1'b0);
        wait_valid();
        px_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, px_valid}, 32'd0);
        chk("mid_rst_data", {8'd0, px_data}, 32'd0);
        px_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        x0 = xfer_cnt;
        start_frame(4, 8'd255);
        for (int i = 0; i < 4; i++) serve(1, 1'b0);
        wait_done();
        chk("rst_refill_xfers", xfer_cnt - x0, 32'd4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
